// File: rtl/pipe_ctrl_v2.sv
// Pipeline controller: prioritised stall arbitration, exception/ERET flush
// and redirect with bus-idle deferral, flush hold and a stall-cycle counter.
module pipe_ctrl_v2 #(
  parameter int                     STAGES       = 8,
  parameter int                     NREQ         = 4,
  parameter logic [NREQ*STAGES-1:0] STALL_PAT    = {8'h7f, 8'h1f, 8'h0f, 8'h07},
  parameter logic [31:0]            EXC_VECTOR   = 32'hbfc00380,
  parameter int                     FLUSH_CYCLES = 1,
  parameter int                     CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              bus_busy,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              redirect,
  output logic              exc_pending,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam bit MULTI = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BUS = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] code_q, code_nx;
  logic [31:0] epc_q, epc_nx;
  logic [FCW-1:0] cnt_q, cnt_nx;

  logic              exc_hit;
  logic [STAGES-1:0] req_pat;
  logic [STAGES-1:0] stall_c;
  logic              flush_c;
  logic              redirect_c;
  logic [31:0]       new_pc_c;
  logic              pend_c;
  logic [CNT_W-1:0]  sc_q;

  function automatic logic [31:0] vec_map(
    input logic [31:0] code,
    input logic [31:0] epc
  );
    logic [31:0] r;
    case (code)
      32'h1, 32'h4, 32'h5, 32'h8,
      32'h9, 32'ha, 32'hc, 32'hd: r = EXC_VECTOR;
      32'he:                      r = epc;
      default:                    r = 32'h0;
    endcase
    return r;
  endfunction

  assign exc_hit = |excepttype_i;

  // Scan downwards so the lowest-index request overwrites the rest.
  always_comb begin
    req_pat = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (stall_req[i]) req_pat = STALL_PAT[i*STAGES +: STAGES];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      code_q <= '0;
      epc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nx;
      code_q <= code_nx;
      epc_q  <= epc_nx;
      cnt_q  <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    epc_nx   = epc_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (exc_hit && !bus_busy) begin
          if (MULTI) begin
            state_nx = FLUSH;
            cnt_nx   = FC_LOAD;
          end
        end else if (exc_hit) begin
          state_nx = WAIT_BUS;
          code_nx  = excepttype_i;
          epc_nx   = cp0_epc_i;
        end
      end
      WAIT_BUS: begin
        if (!bus_busy) begin
          code_nx = '0;
          epc_nx  = '0;
          if (MULTI) begin
            state_nx = FLUSH;
            cnt_nx   = FC_LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      FLUSH: begin
        cnt_nx = cnt_q - 1'b1;
        if (cnt_q <= FCW'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall_c    = '0;
    flush_c    = 1'b0;
    redirect_c = 1'b0;
    new_pc_c   = '0;
    pend_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (exc_hit && !bus_busy) begin
          flush_c    = 1'b1;
          redirect_c = 1'b1;
          new_pc_c   = vec_map(excepttype_i, cp0_epc_i);
        end else if (exc_hit) begin
          stall_c = '1;
        end else begin
          stall_c = req_pat;
        end
      end
      WAIT_BUS: begin
        pend_c = 1'b1;
        if (bus_busy) begin
          stall_c = '1;
        end else begin
          flush_c    = 1'b1;
          redirect_c = 1'b1;
          new_pc_c   = vec_map(code_q, epc_q);
        end
      end
      FLUSH:   flush_c = 1'b1;
      default: ;
    endcase
    if (rst) begin
      stall_c    = '0;
      flush_c    = 1'b0;
      redirect_c = 1'b0;
      new_pc_c   = '0;
      pend_c     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
    end else if ((|stall_c) && !(&sc_q)) begin
      sc_q <= sc_q + 1'b1;
    end
  end

  assign stall        = stall_c;
  assign flush        = flush_c;
  assign new_pc       = new_pc_c;
  assign redirect     = redirect_c;
  assign exc_pending  = pend_c;
  assign stall_cycles = sc_q;

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Bench for pipe_ctrl_v2: two instances (1-cycle flush / 32-bit counter and
// 3-cycle flush / 4-bit counter) checked against a behavioural model.
module tb_pipe_ctrl_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  stall_req;
  logic        bus_busy;
  logic [31:0] excepttype;
  logic [31:0] epc;

  logic [7:0]  o_stall [2];
  logic        o_flush [2];
  logic [31:0] o_npc   [2];
  logic        o_redir [2];
  logic        o_pend  [2];
  logic [31:0] o_sc    [2];
  logic [31:0] sc_a;
  logic [3:0]  sc_b;

  int checks = 0;
  int failures = 0;

  // model state: pending exception, flush cycles still owed, counter
  bit          m_pend [2];
  logic [31:0] m_code [2];
  logic [31:0] m_epc  [2];
  int          m_fl   [2];
  longint      m_cnt  [2];
  int          fc     [2] = '{1, 3};
  longint      cmax   [2] = '{64'hffff_ffff, 64'd15};

  logic [7:0]  e_stall [2];
  logic        e_flush [2];
  logic [31:0] e_npc   [2];
  logic        e_redir [2];
  logic        e_pend  [2];
  logic [31:0] e_sc    [2];

  always #5 clk = ~clk;

  pipe_ctrl_v2 #(
    .FLUSH_CYCLES(1),
    .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .stall_req(stall_req), .bus_busy(bus_busy),
    .excepttype_i(excepttype), .cp0_epc_i(epc),
    .stall(o_stall[0]), .flush(o_flush[0]), .new_pc(o_npc[0]),
    .redirect(o_redir[0]), .exc_pending(o_pend[0]), .stall_cycles(sc_a)
  );

  pipe_ctrl_v2 #(
    .FLUSH_CYCLES(3),
    .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .stall_req(stall_req), .bus_busy(bus_busy),
    .excepttype_i(excepttype), .cp0_epc_i(epc),
    .stall(o_stall[1]), .flush(o_flush[1]), .new_pc(o_npc[1]),
    .redirect(o_redir[1]), .exc_pending(o_pend[1]), .stall_cycles(sc_b)
  );

  assign o_sc[0] = sc_a;
  assign o_sc[1] = {28'b0, sc_b};

  function automatic logic [31:0] vmap(input logic [31:0] c, input logic [31:0] e);
    if (c == 32'h1 || c == 32'h4 || c == 32'h5 || c == 32'h8 ||
        c == 32'h9 || c == 32'ha || c == 32'hc || c == 32'hd)
      return 32'hbfc00380;
    if (c == 32'he) return e;
    return 32'h0;
  endfunction

  function automatic logic [7:0] pat(input logic [3:0] r);
    if (r[0]) return 8'h07;
    if (r[1]) return 8'h0f;
    if (r[2]) return 8'h1f;
    if (r[3]) return 8'h7f;
    return 8'h00;
  endfunction

  task automatic eval();
    for (int k = 0; k < 2; k++) begin
      e_stall[k] = 8'h00;
      e_flush[k] = 1'b0;
      e_npc[k]   = 32'h0;
      e_redir[k] = 1'b0;
      e_pend[k]  = 1'b0;
      e_sc[k]    = 32'(m_cnt[k]);
      if (rst) begin
      end else if (m_fl[k] > 0) begin
        e_flush[k] = 1'b1;
      end else if (m_pend[k]) begin
        e_pend[k] = 1'b1;
        if (bus_busy) begin
          e_stall[k] = 8'hff;
        end else begin
          e_flush[k] = 1'b1;
          e_redir[k] = 1'b1;
          e_npc[k]   = vmap(m_code[k], m_epc[k]);
        end
      end else if (excepttype != 0) begin
        if (bus_busy) begin
          e_stall[k] = 8'hff;
        end else begin
          e_flush[k] = 1'b1;
          e_redir[k] = 1'b1;
          e_npc[k]   = vmap(excepttype, epc);
        end
      end else begin
        e_stall[k] = pat(stall_req);
      end
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k] = 1'b0;
        m_fl[k]   = 0;
        m_cnt[k]  = 0;
      end else begin
        if (e_stall[k] != 0 && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (m_fl[k] > 0) begin
          m_fl[k]--;
        end else if (m_pend[k]) begin
          if (!bus_busy) begin
            m_pend[k] = 1'b0;
            m_fl[k]   = fc[k] - 1;
          end
        end else if (excepttype != 0) begin
          if (bus_busy) begin
            m_pend[k] = 1'b1;
            m_code[k] = excepttype;
            m_epc[k]  = epc;
          end else begin
            m_fl[k] = fc[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    eval();
  endtask

  task automatic adv();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] sr, input logic bb,
                       input logic [31:0] ex, input logic [31:0] ep);
    rst = r; stall_req = sr; bus_busy = bb; excepttype = ex; epc = ep;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 4'h0, 0, 0, 0);
      settle();
      adv();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 4'hf, 1, 32'h8, 32'h1234);
      settle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({o_stall[k], o_flush[k], o_npc[k], o_redir[k], o_pend[k], o_sc[k]} !== 74'h0) begin
          failures++;
          $display("FAIL reset dut%0d: stall=%h flush=%b npc=%h redir=%b pend=%b sc=%0d, want all 0",
                   k, o_stall[k], o_flush[k], o_npc[k], o_redir[k], o_pend[k], o_sc[k]);
        end
      end
      adv();
    end
  endtask

  task automatic test_stall_prio();
    logic [3:0] reqs [5] = '{4'b0110, 4'b1000, 4'b0001, 4'b0100, 4'b0000};
    logic [7:0] want [5] = '{8'h0f, 8'h7f, 8'h07, 8'h1f, 8'h00};
    for (int i = 0; i < 5; i++) begin
      drive(0, reqs[i], $urandom_range(0, 1), 0, $urandom);
      settle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_stall[k] !== want[i] || o_flush[k] !== 1'b0) begin
          failures++;
          $display("FAIL stall_prio dut%0d req=%b: stall=%h flush=%b, want %h/0",
                   k, reqs[i], o_stall[k], o_flush[k], want[i]);
        end
      end
      adv();
    end
  endtask

  task automatic test_exc_direct();
    logic [31:0] codes [4] = '{32'h8, 32'hd, 32'h3, 32'he};
    logic [31:0] want  [4] = '{32'hbfc00380, 32'hbfc00380, 32'h0, 32'h0000_abcc};
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'b0001, 0, codes[i], 32'h0000_abcc);
      settle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_flush[k] !== 1'b1 || o_redir[k] !== 1'b1 ||
            o_npc[k] !== want[i] || o_stall[k] !== 8'h00) begin
          failures++;
          $display("FAIL exc_direct dut%0d code=%h: flush=%b redir=%b npc=%h stall=%h, want 1/1/%h/00",
                   k, codes[i], o_flush[k], o_redir[k], o_npc[k], o_stall[k], want[i]);
        end
      end
      adv();
      idle(3);
    end
  endtask

  task automatic test_exc_bus();
    drive(0, 4'b0010, 1, 32'he, 32'h8000_1234);
    settle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_stall[k] !== 8'hff || o_flush[k] !== 1'b0 || o_redir[k] !== 1'b0) begin
        failures++;
        $display("FAIL exc_bus_entry dut%0d: stall=%h flush=%b redir=%b, want ff/0/0",
                 k, o_stall[k], o_flush[k], o_redir[k]);
      end
    end
    adv();
    for (int c = 0; c < 2; c++) begin
      drive(0, 4'b0001, 1, 32'h8, 32'h5555_0000);
      settle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_stall[k] !== 8'hff || o_pend[k] !== 1'b1 || o_flush[k] !== 1'b0) begin
          failures++;
          $display("FAIL exc_bus_wait dut%0d: stall=%h pend=%b flush=%b, want ff/1/0",
                   k, o_stall[k], o_pend[k], o_flush[k]);
        end
      end
      adv();
    end
    drive(0, 4'b0001, 0, 32'h0, 32'h0);
    settle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_flush[k] !== 1'b1 || o_redir[k] !== 1'b1 ||
          o_npc[k] !== 32'h8000_1234 || o_stall[k] !== 8'h00) begin
        failures++;
        $display("FAIL exc_bus_release dut%0d: flush=%b redir=%b npc=%h stall=%h, want 1/1/80001234/00",
                 k, o_flush[k], o_redir[k], o_npc[k], o_stall[k]);
      end
    end
    adv();
    idle(3);
  endtask

  task automatic test_flush_hold();
    int nf [2];
    int nr [2];
    nf = '{0, 0};
    nr = '{0, 0};
    for (int c = 0; c < 6; c++) begin
      drive(0, 4'b0001, 0, (c == 0) ? 32'h1 : ((c < 3) ? 32'h4 : 32'h0), 32'h0);
      settle();
      for (int k = 0; k < 2; k++) begin
        nf[k] += int'(o_flush[k]);
        nr[k] += int'(o_redir[k]);
      end
      adv();
    end
    checks++;
    if (nf[1] != 3 || nr[1] != 1) begin
      failures++;
      $display("FAIL flush_hold dut1: flush cycles=%0d redirects=%0d, want 3/1", nf[1], nr[1]);
    end
    checks++;
    if (nf[0] != 3 || nr[0] != 3) begin
      failures++;
      $display("FAIL flush_single dut0: flush cycles=%0d redirects=%0d, want 3/3", nf[0], nr[0]);
    end
  endtask

  task automatic test_saturation();
    drive(1, 4'h0, 0, 0, 0);
    settle();
    adv();
    for (int c = 0; c < 20; c++) begin
      drive(0, 4'b0001, $urandom_range(0, 1), 0, 0);
      settle();
      adv();
    end
    drive(0, 4'b0000, 0, 0, 0);
    settle();
    checks++;
    if (o_sc[1] !== 32'd15) begin
      failures++;
      $display("FAIL saturation dut1: stall_cycles=%0d, want 15", o_sc[1]);
    end
    checks++;
    if (o_sc[0] !== 32'd20) begin
      failures++;
      $display("FAIL count dut0: stall_cycles=%0d, want 20", o_sc[0]);
    end
    adv();
  endtask

  task automatic test_reset_mid_wait();
    int nr;
    nr = 0;
    drive(0, 4'h0, 1, 32'h8, 32'h0);
    settle();
    adv();
    drive(1, 4'h3, 1, 32'h0, 32'h0);
    settle();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_stall[k], o_flush[k], o_npc[k], o_redir[k], o_pend[k]} !== 42'h0) begin
        failures++;
        $display("FAIL rst_mid_wait dut%0d: stall=%h flush=%b npc=%h redir=%b pend=%b, want 0",
                 k, o_stall[k], o_flush[k], o_npc[k], o_redir[k], o_pend[k]);
      end
    end
    adv();
    for (int c = 0; c < 4; c++) begin
      drive(0, 4'h0, 0, 32'h0, 32'h0);
      settle();
      nr += int'(o_redir[0]) + int'(o_redir[1]) + int'(o_pend[0]) + int'(o_pend[1]);
      adv();
    end
    checks++;
    if (nr != 0) begin
      failures++;
      $display("FAIL rst_mid_wait_after: redirect/pending cycles=%0d, want 0", nr);
    end
  endtask

  task automatic test_random();
    logic [31:0] codes [12] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha,
                                32'hc, 32'hd, 32'he, 32'h2, 32'h3, 32'h20};
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 59) == 0, 4'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 6) ? 32'h0 : codes[$urandom_range(0, 11)], $urandom);
      settle();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({o_stall[k], o_flush[k], o_npc[k], o_redir[k], o_pend[k], o_sc[k]} !==
            {e_stall[k], e_flush[k], e_npc[k], e_redir[k], e_pend[k], e_sc[k]}) begin
          failures++;
          $display("FAIL random c%0d dut%0d: got st=%h fl=%b pc=%h rd=%b pe=%b sc=%0d want st=%h fl=%b pc=%h rd=%b pe=%b sc=%0d",
                   c, k, o_stall[k], o_flush[k], o_npc[k], o_redir[k], o_pend[k], o_sc[k],
                   e_stall[k], e_flush[k], e_npc[k], e_redir[k], e_pend[k], e_sc[k]);
        end
      end
      adv();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0;
      m_code[k] = '0;
      m_epc[k]  = '0;
      m_fl[k]   = 0;
      m_cnt[k]  = 0;
    end
    drive(1, 4'h0, 0, 0, 0);
    test_reset();
    test_stall_prio();
    test_exc_direct();
    test_exc_bus();
    test_flush_hold();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
